memory_stage_pipe: RTL and testbench

Parametrised memory stage with integrated MEM/WB pipeline register for the pipelined ARM core. It drives a data-memory port with a ready handshake and stalls the upstream pipeline while an access waits. It supports word and byte loads and stores, plus a configurable write-data increment. A bounded wait-state timeout turns a hung access into a bubble and raises a sticky error flag.

---
 rtl/memory_stage_pipe.sv | 199 +++++++++++++++++++
 tb/tb_memory_stage_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage_pipe.sv
// memory_stage_pipe: memory stage of the pipelined ARM core with the MEM/WB
// register folded in. Drives a ready-handshake data-memory port, stalls the
// upstream stages while an access waits, and turns an access that waits too
// long into a bubble and a sticky timeout error.
module memory_stage_pipe #(
  parameter int WIDTH    = 32,
  parameter int RA_W     = 4,
  parameter int INC_STEP = 1,
  parameter int MAX_WAIT = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               valid_m,
  input  logic               mem_read_m,
  input  logic               mem_write_m,
  input  logic               byte_m,
  input  logic               plus_one_m,
  input  logic               mem_to_reg_m,
  input  logic               pc_src_m,
  input  logic               reg_write_m,
  input  logic [WIDTH-1:0]   alu_out_m,
  input  logic [WIDTH-1:0]   write_data_m,
  input  logic [RA_W-1:0]    wa3_m,
  input  logic               flush,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [WIDTH-1:0]   dmem_addr,
  output logic [WIDTH-1:0]   dmem_wdata,
  output logic [WIDTH/8-1:0] dmem_be,
  input  logic [WIDTH-1:0]   dmem_rdata,
  input  logic               dmem_ready,
  output logic               stall_m,
  output logic               valid_w,
  output logic               mem_to_reg_w,
  output logic               pc_src_w,
  output logic               reg_write_w,
  output logic [WIDTH-1:0]   alu_out_w,
  output logic [WIDTH-1:0]   read_data_w,
  output logic [RA_W-1:0]    wa3_w,
  output logic               err_timeout
);

  localparam int NB = WIDTH / 8;
  localparam int LW = $clog2(NB);
  localparam int CW = $clog2(MAX_WAIT + 1);

  localparam logic [CW-1:0]    MAXW_C = CW'(MAX_WAIT);
  localparam logic [CW-1:0]    ONE_C  = CW'(1);
  localparam logic [WIDTH-1:0] INC_C  = WIDTH'(INC_STEP);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    wcnt_r, wcnt_s;
  logic             err_r, err_s;

  logic             access_s;
  logic             is_load_s;
  logic             abort_s;
  logic             req_s;
  logic             stall_s;
  logic             bubble_s;
  logic [LW-1:0]    lane_s;
  logic [WIDTH-1:0] sd_s;
  logic [WIDTH-1:0] load_data_s;

  // Pick byte 'lane' out of a word and zero-extend it.
  function automatic logic [WIDTH-1:0] lane_byte(input logic [WIDTH-1:0] word,
                                                 input logic [LW-1:0]    lane);
    logic [WIDTH-1:0] shifted;
    shifted   = word >> {lane, 3'b000};
    lane_byte = {{(WIDTH-8){1'b0}}, shifted[7:0]};
  endfunction

  // Request decode, store-data formatting and load-data extraction.
  always_comb begin
    access_s  = valid_m & (mem_read_m | mem_write_m);
    is_load_s = access_s & mem_read_m & ~mem_write_m;
    lane_s    = alu_out_m[LW-1:0];
    if (plus_one_m) begin
      sd_s = write_data_m + INC_C;
    end else begin
      sd_s = write_data_m;
    end
    if (byte_m) begin
      dmem_be    = {{(NB-1){1'b0}}, 1'b1} << lane_s;
      dmem_wdata = {NB{sd_s[7:0]}};
    end else begin
      dmem_be    = {NB{1'b1}};
      dmem_wdata = sd_s;
    end
    if (!is_load_s) begin
      load_data_s = {WIDTH{1'b0}};
    end else if (byte_m) begin
      load_data_s = lane_byte(dmem_rdata, lane_s);
    end else begin
      load_data_s = dmem_rdata;
    end
    dmem_addr = alu_out_m;
  end

  // Handshake outputs, abort detection and stall generation.
  always_comb begin
    if (state_r == ST_WAIT) begin
      req_s = 1'b1;
    end else begin
      req_s = access_s;
    end
    abort_s  = (state_r == ST_WAIT) & (wcnt_r == MAXW_C) & ~dmem_ready;
    stall_s  = req_s & ~dmem_ready & ~abort_s;
    bubble_s = flush | stall_s | abort_s;
    dmem_req = req_s;
    dmem_we  = req_s & mem_write_m;
    stall_m  = stall_s;
  end

  // Next-state logic for the wait FSM, wait counter and sticky error.
  always_comb begin
    state_s = state_r;
    wcnt_s  = wcnt_r;
    err_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (access_s && !dmem_ready) begin
          state_s = ST_WAIT;
          wcnt_s  = ONE_C;
        end else begin
          state_s = ST_IDLE;
          wcnt_s  = {CW{1'b0}};
        end
      end
      ST_WAIT: begin
        if (dmem_ready) begin
          state_s = ST_IDLE;
          wcnt_s  = {CW{1'b0}};
        end else if (wcnt_r == MAXW_C) begin
          state_s = ST_IDLE;
          wcnt_s  = {CW{1'b0}};
          err_s   = 1'b1;
        end else begin
          state_s = ST_WAIT;
          wcnt_s  = wcnt_r + ONE_C;
        end
      end
      default: begin
        state_s = ST_IDLE;
        wcnt_s  = {CW{1'b0}};
      end
    endcase
  end

  // FSM state, wait counter and sticky timeout flag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      wcnt_r  <= {CW{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      wcnt_r  <= wcnt_s;
      err_r   <= err_s;
    end
  end

  // MEM/WB pipeline register: bubble on flush, stall or abort, else capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_w      <= 1'b0;
      mem_to_reg_w <= 1'b0;
      pc_src_w     <= 1'b0;
      reg_write_w  <= 1'b0;
      alu_out_w    <= {WIDTH{1'b0}};
      read_data_w  <= {WIDTH{1'b0}};
      wa3_w        <= {RA_W{1'b0}};
    end else if (bubble_s) begin
      valid_w      <= 1'b0;
      mem_to_reg_w <= 1'b0;
      pc_src_w     <= 1'b0;
      reg_write_w  <= 1'b0;
      alu_out_w    <= {WIDTH{1'b0}};
      read_data_w  <= {WIDTH{1'b0}};
      wa3_w        <= {RA_W{1'b0}};
    end else begin
      valid_w      <= valid_m;
      mem_to_reg_w <= mem_to_reg_m;
      pc_src_w     <= pc_src_m;
      reg_write_w  <= reg_write_m;
      alu_out_w    <= alu_out_m;
      read_data_w  <= load_data_s;
      wa3_w        <= wa3_m;
    end
  end

  assign err_timeout = err_r;

endmodule

// File: tb/tb_memory_stage_pipe.sv
// Directed testbench for memory_stage_pipe with default parameters.
module tb_memory_stage_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_m, mem_read_m, mem_write_m, byte_m, plus_one_m;
  logic        mem_to_reg_m, pc_src_m, reg_write_m;
  logic [31:0] alu_out_m, write_data_m;
  logic [3:0]  wa3_m;
  logic        flush;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        stall_m;
  logic        valid_w, mem_to_reg_w, pc_src_w, reg_write_w;
  logic [31:0] alu_out_w, read_data_w;
  logic [3:0]  wa3_w;
  logic        err_timeout;

  int vectors   = 0;
  int miscompares = 0;
  int stall_cnt;

  memory_stage_pipe dut (
    .clock(clock), .reset(reset),
    .valid_m(valid_m), .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
    .byte_m(byte_m), .plus_one_m(plus_one_m),
    .mem_to_reg_m(mem_to_reg_m), .pc_src_m(pc_src_m), .reg_write_m(reg_write_m),
    .alu_out_m(alu_out_m), .write_data_m(write_data_m), .wa3_m(wa3_m),
    .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .stall_m(stall_m),
    .valid_w(valid_w), .mem_to_reg_w(mem_to_reg_w), .pc_src_w(pc_src_w),
    .reg_write_w(reg_write_w), .alu_out_w(alu_out_w), .read_data_w(read_data_w),
    .wa3_w(wa3_w), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    valid_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0; byte_m = 1'b0;
    plus_one_m = 1'b0; mem_to_reg_m = 1'b0; pc_src_m = 1'b0; reg_write_m = 1'b0;
    alu_out_m = 32'h0; write_data_m = 32'h0; wa3_m = 4'h0; flush = 1'b0;
    dmem_rdata = 32'h0; dmem_ready = 1'b0;
  endtask

  task automatic check_wb_zero(input string tag);
    check({tag, "_valid_w"}, {31'd0, valid_w}, 32'd0);
    check({tag, "_reg_write_w"}, {31'd0, reg_write_w}, 32'd0);
    check({tag, "_mem_to_reg_w"}, {31'd0, mem_to_reg_w}, 32'd0);
    check({tag, "_alu_out_w"}, alu_out_w, 32'd0);
    check({tag, "_read_data_w"}, read_data_w, 32'd0);
    check({tag, "_wa3_w"}, {28'd0, wa3_w}, 32'd0);
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    idle_inputs();
    #12;
    check_wb_zero("rst");
    check("rst_err", {31'd0, err_timeout}, 32'd0);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    reset = 1'b1;
    tick();

    // ALU instruction passes straight through
    valid_m = 1'b1; reg_write_m = 1'b1; alu_out_m = 32'h1234; wa3_m = 4'd5;
    #1;
    check("alu_stall", {31'd0, stall_m}, 32'd0);
    check("alu_req", {31'd0, dmem_req}, 32'd0);
    tick();
    check("alu_valid_w", {31'd0, valid_w}, 32'd1);
    check("alu_alu_out_w", alu_out_w, 32'h1234);
    check("alu_wa3_w", {28'd0, wa3_w}, 32'd5);
    check("alu_reg_write_w", {31'd0, reg_write_w}, 32'd1);
    check("alu_read_data_w", read_data_w, 32'd0);

    // Word store with increment, zero wait
    reg_write_m = 1'b0; mem_write_m = 1'b1; write_data_m = 32'h7; plus_one_m = 1'b1;
    alu_out_m = 32'h100; wa3_m = 4'd0; dmem_ready = 1'b1;
    #1;
    check("wst_wdata", dmem_wdata, 32'h8);
    check("wst_be", {28'd0, dmem_be}, 32'hF);
    check("wst_we", {31'd0, dmem_we}, 32'd1);
    check("wst_req", {31'd0, dmem_req}, 32'd1);
    check("wst_addr", dmem_addr, 32'h100);
    check("wst_stall", {31'd0, stall_m}, 32'd0);
    tick();
    check("wst_valid_w", {31'd0, valid_w}, 32'd1);
    check("wst_alu_out_w", alu_out_w, 32'h100);

    // Byte load at 0x102, ready after two wait cycles
    mem_write_m = 1'b0; plus_one_m = 1'b0; write_data_m = 32'h0;
    mem_read_m = 1'b1; byte_m = 1'b1; mem_to_reg_m = 1'b1; reg_write_m = 1'b1;
    alu_out_m = 32'h102; wa3_m = 4'd3; dmem_rdata = 32'hAABBCCDD; dmem_ready = 1'b0;
    #1;
    check("bld_stall0", {31'd0, stall_m}, 32'd1);
    check("bld_we0", {31'd0, dmem_we}, 32'd0);
    tick();
    check("bld_bubble1", {31'd0, valid_w}, 32'd0);
    check("bld_stall1", {31'd0, stall_m}, 32'd1);
    tick();
    check("bld_bubble2", {31'd0, valid_w}, 32'd0);
    dmem_ready = 1'b1;
    #1;
    check("bld_stall2", {31'd0, stall_m}, 32'd0);
    tick();
    check("bld_read_data_w", read_data_w, 32'h000000BB);
    check("bld_valid_w", {31'd0, valid_w}, 32'd1);
    check("bld_mem_to_reg_w", {31'd0, mem_to_reg_w}, 32'd1);
    check("bld_wa3_w", {28'd0, wa3_w}, 32'd3);

    // Byte store at lane 3
    mem_read_m = 1'b0; mem_to_reg_m = 1'b0; reg_write_m = 1'b0;
    mem_write_m = 1'b1; alu_out_m = 32'h3; write_data_m = 32'h5A;
    #1;
    check("bst_be", {28'd0, dmem_be}, 32'h8);
    check("bst_wdata", dmem_wdata, 32'h5A5A5A5A);
    check("bst_stall", {31'd0, stall_m}, 32'd0);
    tick();

    // Ready with no request is ignored
    idle_inputs();
    dmem_ready = 1'b1;
    #1;
    check("nreq_req", {31'd0, dmem_req}, 32'd0);
    check("nreq_stall", {31'd0, stall_m}, 32'd0);
    tick();
    check("nreq_valid_w", {31'd0, valid_w}, 32'd0);

    // Timeout: load never acknowledged
    valid_m = 1'b1; mem_read_m = 1'b1; reg_write_m = 1'b1; alu_out_m = 32'h40;
    dmem_ready = 1'b0;
    #1;
    stall_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!stall_m) break;
      stall_cnt++;
      tick();
    end
    check("to_stall_cycles", stall_cnt, 32'd15);
    check("to_abort_req", {31'd0, dmem_req}, 32'd1);
    check("to_err_before", {31'd0, err_timeout}, 32'd0);
    tick();
    check("to_err_set", {31'd0, err_timeout}, 32'd1);
    check("to_bubble", {31'd0, valid_w}, 32'd0);
    idle_inputs();
    tick();
    tick();
    check("to_err_sticky", {31'd0, err_timeout}, 32'd1);

    // Flush coincident with a completing load
    valid_m = 1'b1; mem_read_m = 1'b1; reg_write_m = 1'b1; mem_to_reg_m = 1'b1;
    alu_out_m = 32'h200; wa3_m = 4'd7; dmem_rdata = 32'h11223344; dmem_ready = 1'b1;
    flush = 1'b1;
    #1;
    check("fl_stall", {31'd0, stall_m}, 32'd0);
    tick();
    check_wb_zero("fl");

    // Same load without flush completes
    flush = 1'b0;
    tick();
    check("nf_read_data_w", read_data_w, 32'h11223344);

    // Reset asserted while in WAIT
    dmem_ready = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    check_wb_zero("rw");
    check("rw_err_clr", {31'd0, err_timeout}, 32'd0);
    check("rw_req_follows", {31'd0, dmem_req}, 32'd1);
    valid_m = 1'b0;
    #1;
    check("rw_idle_req", {31'd0, dmem_req}, 32'd0);
    reset = 1'b1;
    tick();
    check("rw_after_req", {31'd0, dmem_req}, 32'd0);
    check("rw_after_stall", {31'd0, stall_m}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
